// File: rtl/hemaia_reset_sequencer_if.sv
// Sequence-request channel between a requester (CSR/software) and the reset sequencer.
// Field names keep the sequencer's point of view (_i into the sequencer, _o out of it).
interface hemaia_reset_sequencer_if #(
    parameter int unsigned NumReset = 4,
    parameter int unsigned CntWidth = 8
) ();
    logic                seq_valid_i;
    logic                seq_ready_o;
    logic [NumReset-1:0] seq_mask_i;
    logic [CntWidth-1:0] seq_pulse_i;
    logic [CntWidth-1:0] seq_gap_i;
    logic                seq_ack_o;

    modport slave (
        input  seq_valid_i, seq_mask_i, seq_pulse_i, seq_gap_i,
        output seq_ready_o, seq_ack_o
    );

    modport master (
        output seq_valid_i, seq_mask_i, seq_pulse_i, seq_gap_i,
        input  seq_ready_o, seq_ack_o
    );
endinterface

// File: rtl/hemaia_reset_sequencer.sv
// Reset sequencer: asserts selected channels together for a pulse, then releases them
// one by one in ascending index order with a fixed gap. Runs a power-on sequence first.
module hemaia_reset_sequencer #(
    parameter int unsigned NumReset     = 4,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned DefaultPulse = 8,
    parameter int unsigned DefaultGap   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hemaia_reset_sequencer_if.slave seq_if,
    output logic                  boot_done_o,
    output logic [NumReset-1:0]   rst_no
);

    typedef enum logic [1:0] {BOOT, IDLE, ASSERT, RELEASE} state_e;

    state_e              state_q;
    logic [NumReset-1:0] rst_n_q;
    logic [NumReset-1:0] pend_q;
    logic [CntWidth-1:0] pulse_q;
    logic [CntWidth-1:0] gap_q;
    logic [CntWidth-1:0] cnt_q;
    logic                ready_q;
    logic                ack_q;
    logic                boot_done_q;
    logic                boot_seq_q;

    logic [NumReset-1:0] low_bit;
    logic [NumReset-1:0] rel_bits;
    logic                rel_last;
    logic                release_now;
    logic                accept;
    logic [CntWidth-1:0] pulse_m1;
    logic [CntWidth-1:0] gap_m1;

    // Lowest pending channel; a zero gap releases every pending channel at once.
    assign low_bit  = pend_q & (~pend_q + NumReset'(1));
    assign rel_bits = (gap_q == '0) ? pend_q : low_bit;
    assign rel_last = ((pend_q & ~rel_bits) == '0);
    assign pulse_m1 = (pulse_q == '0) ? '0 : pulse_q - CntWidth'(1);
    assign gap_m1   = (gap_q == '0) ? '0 : gap_q - CntWidth'(1);
    assign accept   = seq_if.seq_valid_i & ready_q;

    always_comb begin
        release_now = 1'b0;
        if (state_q == ASSERT) begin
            release_now = (cnt_q >= pulse_m1);
        end else if (state_q == RELEASE) begin
            release_now = (pend_q != '0) && (cnt_q >= gap_m1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            rst_n_q     <= '0;
            pend_q      <= '0;
            pulse_q     <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            boot_done_q <= 1'b0;
            boot_seq_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    pend_q     <= '1;
                    pulse_q    <= CntWidth'(DefaultPulse);
                    gap_q      <= CntWidth'(DefaultGap);
                    cnt_q      <= '0;
                    rst_n_q    <= '0;
                    boot_seq_q <= 1'b1;
                    state_q    <= ASSERT;
                end
                IDLE: begin
                    if (accept) begin
                        ready_q    <= 1'b0;
                        pend_q     <= seq_if.seq_mask_i;
                        pulse_q    <= seq_if.seq_pulse_i;
                        gap_q      <= seq_if.seq_gap_i;
                        cnt_q      <= '0;
                        boot_seq_q <= 1'b0;
                        // An empty mask skips straight to completion.
                        if (seq_if.seq_mask_i == '0) begin
                            ack_q   <= 1'b1;
                            state_q <= RELEASE;
                        end else begin
                            rst_n_q <= rst_n_q & ~seq_if.seq_mask_i;
                            state_q <= ASSERT;
                        end
                    end
                end
                ASSERT: begin
                    if (release_now) begin
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                RELEASE: begin
                    if (pend_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (!release_now) begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: state_q <= BOOT;
            endcase

            if (release_now) begin
                rst_n_q <= rst_n_q | rel_bits;
                pend_q  <= pend_q & ~rel_bits;
                cnt_q   <= '0;
                if (rel_last) begin
                    ack_q <= 1'b1;
                    if (boot_seq_q) begin
                        boot_done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign rst_no             = rst_n_q;
    assign boot_done_o        = boot_done_q;
    assign seq_if.seq_ready_o = ready_q;
    assign seq_if.seq_ack_o   = ack_q;

endmodule
